// File: rtl/sfx_pkg.sv
// Shared constants, state encoding and amplitude helper for the sound-effect engine.
package sfx_pkg;

    localparam int AMP_STEP = 200;
    localparam int VOL_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic logic [10:0] amp_of(input logic [VOL_W-1:0] vol);
        return 11'(int'(vol) * AMP_STEP);
    endfunction

endpackage

// File: rtl/sfx_square_osc.sv
// Square-wave phase generator: half-period of div cycles, restartable.
module sfx_square_osc
    import sfx_pkg::*;
#(
    parameter int DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             phase
);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (restart) begin
            div_cnt <= '0;
            phase   <= 1'b1;
        end else if (div != '0) begin
            if (div_cnt == div - 1'b1) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfx_tone_engine.sv
// Event-driven square-wave sound-effect engine with fixed-priority arbitration.
// Optional amplitude decay is built when SFX_DECAY_EN is defined.
module sfx_tone_engine
    import sfx_pkg::*;
#(
    parameter  int N_EV      = 4,
    parameter  int DIV_W     = 22,
    parameter  int DUR_W     = 27,
    parameter  int DECAY_CYC = 12_500_000,
    localparam int AW        = (N_EV > 1) ? $clog2(N_EV) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_EV-1:0]         ev_pulse,
    input  logic [N_EV*DIV_W-1:0]   ev_div,
    input  logic [N_EV*DUR_W-1:0]   ev_dur,
    input  logic [N_EV*2-1:0]       ev_pan,
    input  logic [VOL_W-1:0]        volume,
    output logic signed [15:0]      audio_left,
    output logic signed [15:0]      audio_right,
    output logic                    busy,
    output logic [AW-1:0]           active_ev,
    output logic                    tone_on,
    output logic                    drop
);

    if (N_EV < 1 || N_EV > 8 || DECAY_CYC < 1) begin : g_bad_param
        $error("sfx_tone_engine: parameter out of range");
    end

    state_t           state;
    logic [DIV_W-1:0] div_lat;
    logic [DUR_W-1:0] dur_cnt;
    logic [1:0]       pan_lat;
    logic             phase;

    logic [N_EV-1:0]  req;
    logic [N_EV-1:0]  win_oh;
    logic [AW-1:0]    win;
    logic             win_vld;
    logic             start;
    logic             drop_nxt;
    logic             note_end;
    logic [10:0]      amp;
    logic [10:0]      amp_eff;
    logic signed [15:0] s;

    // Highest-index valid strobe wins; the loop order makes later hits override.
    always_comb begin
        req     = '0;
        win_oh  = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N_EV; i++) begin
            req[i] = ev_pulse[i] && (ev_dur[i*DUR_W +: DUR_W] != '0);
            if (req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win       = AW'(i);
                win_vld   = 1'b1;
            end
        end
    end

    assign start    = win_vld && (state == IDLE || win >= active_ev);
    assign drop_nxt = (|(req & ~win_oh)) || (win_vld && !start);
    assign amp      = amp_of(volume);

`ifdef SFX_DECAY_EN
    localparam int DC_W = $clog2(DECAY_CYC + 1);

    logic [DC_W-1:0] decay_cnt;
    logic [3:0]      shift;

    assign amp_eff  = amp >> shift;
    assign note_end = (dur_cnt == '0) || (amp_eff == '0);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            decay_cnt <= '0;
            shift     <= '0;
        end else if (state == PLAY) begin
            if (decay_cnt == DC_W'(DECAY_CYC - 1)) begin
                decay_cnt <= '0;
                if (shift != 4'hf) shift <= shift + 1'b1;
            end else begin
                decay_cnt <= decay_cnt + 1'b1;
            end
        end
    end
`else
    assign amp_eff  = amp;
    assign note_end = (dur_cnt == '0);
`endif

    always_comb begin
        s = '0;
        if (state == PLAY && div_lat != '0 && amp_eff != '0)
            s = phase ? 16'(amp_eff) : -16'(amp_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_ev   <= '0;
            div_lat     <= '0;
            dur_cnt     <= '0;
            pan_lat     <= '0;
            drop        <= 1'b0;
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            drop        <= drop_nxt;
            audio_left  <= pan_lat[1] ? s : 16'sd0;
            audio_right <= pan_lat[0] ? s : 16'sd0;
            if (start) begin
                state     <= PLAY;
                active_ev <= win;
                div_lat   <= ev_div[win*DIV_W +: DIV_W];
                dur_cnt   <= ev_dur[win*DUR_W +: DUR_W] - 1'b1;
                pan_lat   <= ev_pan[win*2 +: 2];
            end else begin
                unique case (state)
                    IDLE: ;
                    PLAY: begin
                        if (note_end) begin
                            state     <= IDLE;
                            active_ev <= '0;
                        end else begin
                            dur_cnt <= dur_cnt - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign busy    = (state == PLAY);
    assign tone_on = (state == PLAY) && (div_lat != '0);

    sfx_square_osc #(
        .DIV_W(DIV_W)
    ) u_osc (
        .clk    (clk),
        .rst    (rst),
        .restart(start),
        .div    (div_lat),
        .phase  (phase)
    );

endmodule

// File: tb/tb_sfx_tone_engine.sv
// Scoreboard bench for sfx_tone_engine against an elapsed-time reference model.
module tb_sfx_tone_engine;

    localparam int N_EV  = 4;
    localparam int DIV_W = 22;
    localparam int DUR_W = 27;

    typedef struct {
        logic              busy;
        logic [1:0]        act;
        logic              tone;
        logic              drop;
        logic signed [15:0] l;
        logic signed [15:0] r;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_EV-1:0]         ev_pulse = '0;
    logic [N_EV*DIV_W-1:0]   ev_div = '0;
    logic [N_EV*DUR_W-1:0]   ev_dur = '0;
    logic [N_EV*2-1:0]       ev_pan = '0;
    logic [2:0]              volume = 3'd5;
    logic signed [15:0]      audio_left;
    logic signed [15:0]      audio_right;
    logic                    busy;
    logic [1:0]              active_ev;
    logic                    tone_on;
    logic                    drop;

    sfx_tone_engine #(
        .N_EV (N_EV),
        .DIV_W(DIV_W),
        .DUR_W(DUR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_pulse   (ev_pulse),
        .ev_div     (ev_div),
        .ev_dur     (ev_dur),
        .ev_pan     (ev_pan),
        .volume     (volume),
        .audio_left (audio_left),
        .audio_right(audio_right),
        .busy       (busy),
        .active_ev  (active_ev),
        .tone_on    (tone_on),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a note is described by when it started and how long it lasts.
    bit   m_play = 0;
    int   m_idx = 0;
    int   m_div = 0;
    int   m_pan = 0;
    int   m_elapsed = 0;
    int   m_left = 0;

    function automatic int div_of(int i);
        return int'(ev_div[i*DIV_W +: DIV_W]);
    endfunction

    function automatic int dur_of(int i);
        return int'(ev_dur[i*DUR_W +: DUR_W]);
    endfunction

    task automatic model_step();
        exp_t e;
        int   amp, smp, w, nreq;
        bit   st;
        amp = int'(volume) * 200;
        smp = 0;
        if (m_play && m_div != 0 && amp != 0)
            smp = ((m_elapsed / m_div) % 2 == 0) ? amp : -amp;
        e.l = 16'((m_pan & 2) != 0 ? smp : 0);
        e.r = 16'((m_pan & 1) != 0 ? smp : 0);
        w = -1;
        nreq = 0;
        for (int i = 0; i < N_EV; i++) begin
            if (ev_pulse[i] && dur_of(i) != 0) begin
                w = i;
                nreq++;
            end
        end
        st = (w >= 0) && (!m_play || w >= m_idx);
        e.drop = (nreq > 1) || (w >= 0 && !st);
        if (rst) begin
            m_play = 0; m_idx = 0; m_div = 0; m_pan = 0;
            e.l = 0; e.r = 0; e.drop = 0;
        end else if (st) begin
            m_play = 1; m_idx = w; m_div = div_of(w);
            m_pan = int'(ev_pan[w*2 +: 2]);
            m_elapsed = 0; m_left = dur_of(w);
        end else if (m_play) begin
            m_elapsed++;
            m_left--;
            if (m_left == 0) begin
                m_play = 0;
                m_idx = 0;
            end
        end
        e.busy = m_play;
        e.act  = 2'(m_play ? m_idx : 0);
        e.tone = m_play && m_div != 0;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [N_EV-1:0] p, input logic r);
        ev_pulse = p;
        rst = r;
        model_step();
        @(negedge clk);
        ev_pulse = '0;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, 1'b0);
    endtask

    task automatic set_ev(input int i, input int d, input int du, input int p);
        ev_div[i*DIV_W +: DIV_W] = DIV_W'(d);
        ev_dur[i*DUR_W +: DUR_W] = DUR_W'(du);
        ev_pan[i*2 +: 2] = 2'(p);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk("busy", int'(busy), int'(e.busy));
                chk("active_ev", int'(active_ev), int'(e.act));
                chk("tone_on", int'(tone_on), int'(e.tone));
                chk("drop", int'(drop), int'(e.drop));
                chk("audio_left", int'(audio_left), int'(e.l));
                chk("audio_right", int'(audio_right), int'(e.r));
            end
        end
    end

    initial begin
        int budget;
        @(negedge clk);
        drive('0, 1'b1);
        drive('0, 1'b1);
        idle(2);
        // single note, 20 cycles, full pan
        volume = 3'd5;
        set_ev(0, 4, 20, 3);
        drive(4'b0001, 1'b0);
        idle(25);
        // higher preempts, lower is dropped
        set_ev(1, 5, 100, 3);
        set_ev(3, 3, 60, 1);
        set_ev(2, 2, 30, 2);
        drive(4'b0010, 1'b0);
        idle(9);
        drive(4'b1000, 1'b0);
        set_ev(3, 7, 7, 0);
        idle(9);
        drive(4'b0100, 1'b0);
        idle(60);
        // simultaneous strobes, then zero-duration strobe
        set_ev(0, 2, 15, 3);
        set_ev(2, 3, 12, 3);
        drive(4'b0101, 1'b0);
        idle(15);
        set_ev(1, 3, 0, 3);
        drive(4'b0010, 1'b0);
        idle(3);
        // rest note and left-only pan
        set_ev(0, 0, 50, 3);
        drive(4'b0001, 1'b0);
        idle(52);
        set_ev(1, 3, 20, 2);
        drive(4'b0010, 1'b0);
        idle(22);
        // reset mid-note, then replay
        set_ev(2, 2, 40, 3);
        drive(4'b0100, 1'b0);
        idle(10);
        drive('0, 1'b1);
        idle(2);
        drive(4'b0100, 1'b0);
        idle(42);
        // same-index retrigger and div==1
        set_ev(3, 1, 10, 3);
        drive(4'b1000, 1'b0);
        idle(4);
        drive(4'b1000, 1'b0);
        idle(12);
        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            logic [N_EV-1:0] p;
            if ($urandom_range(0, 6) == 0) begin
                int i;
                i = $urandom_range(0, N_EV - 1);
                set_ev(i, $urandom_range(0, 6),
                       ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40),
                       $urandom_range(0, 3));
            end
            if ($urandom_range(0, 30) == 0) volume = 3'($urandom_range(0, 7));
            p = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
            drive(p, ($urandom_range(0, 400) == 0) ? 1'b1 : 1'b0);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
